// File: rtl/coin_acceptor.sv
// Coin-chute front end: synchronises and debounces the two optical sensors,
// classifies each coin and issues a valid/reject strobe or a jam level.
module coin_acceptor #(
   parameter int unsigned DEB_CYCLES = 4,
   parameter int unsigned MAX_PULSE  = 64,
   parameter int unsigned CNT_W      = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic sense_a,
   input  logic sense_b,
   input  logic busy,
   output logic i,
   output logic j,
   output logic reject,
   output logic jam
);

   typedef enum logic [2:0] {
      IDLE,
      DEBOUNCE,
      WAIT_RELEASE,
      EMIT,
      REJECT,
      JAM
   } state_t;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_PULSE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state;
   logic [1:0]       sync_a;
   logic [1:0]       sync_b;
   logic [1:0]       pat;
   logic [1:0]       pat_q;
   logic [CNT_W-1:0] cnt;
   logic             cls;
   logic             ok;
   logic             drop;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= {sync_a[0], sense_a};
         sync_b <= {sync_b[0], sense_b};
      end
   end

   assign pat = {sync_a[1], sync_b[1]};

   // Outputs are registered alongside the state so each strobe is asserted
   // exactly while the FSM sits in the matching state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         pat_q  <= '0;
         cnt    <= '0;
         cls    <= 1'b0;
         ok     <= 1'b0;
         drop   <= 1'b0;
         i      <= 1'b0;
         j      <= 1'b0;
         reject <= 1'b0;
         jam    <= 1'b0;
      end else begin
         i      <= 1'b0;
         j      <= 1'b0;
         reject <= 1'b0;
         case (state)
            IDLE: begin
               if (pat != 2'b00) begin
                  pat_q <= pat;
                  cnt   <= CNT_ONE;
                  state <= DEBOUNCE;
               end
            end
            DEBOUNCE: begin
               if (pat == 2'b00) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else if (pat != pat_q) begin
                  pat_q <= pat;
                  cnt   <= CNT_ONE;
               end else if (cnt >= DEB_LAST) begin
                  // 10 = small, 11 = large, 01 = invalid
                  ok    <= pat_q[1];
                  cls   <= pat_q[1] & pat_q[0];
                  drop  <= busy;
                  cnt   <= '0;
                  state <= WAIT_RELEASE;
               end else begin
                  cnt <= sat_inc(cnt);
               end
            end
            WAIT_RELEASE: begin
               if (pat == 2'b00) begin
                  cnt <= '0;
                  if (ok && !drop) begin
                     i     <= 1'b1;
                     j     <= cls;
                     state <= EMIT;
                  end else begin
                     reject <= 1'b1;
                     state  <= REJECT;
                  end
               end else if (cnt >= MAX_LAST) begin
                  cnt   <= '0;
                  jam   <= 1'b1;
                  state <= JAM;
               end else begin
                  cnt <= sat_inc(cnt);
               end
            end
            EMIT, REJECT: begin
               state <= IDLE;
            end
            JAM: begin
               if (pat != 2'b00) begin
                  cnt <= '0;
               end else if (cnt >= DEB_LAST) begin
                  cnt   <= '0;
                  jam   <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= sat_inc(cnt);
               end
            end
            default: begin
               cnt   <= '0;
               jam   <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: every expectation is a hand-computed
// constant (sync latency 2, DEB_CYCLES 4, MAX_PULSE 16).
module tb_coin_acceptor;

   logic clk = 1'b0;
   logic rst;
   logic sense_a;
   logic sense_b;
   logic busy;
   logic i;
   logic j;
   logic reject;
   logic jam;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   int n_i = 0;
   int n_rej = 0;
   int n_jam = 0;
   int n_jam_rise = 0;
   int n_bad = 0;
   int last_j = 0;
   int i_cyc = 0;
   int jam_rise = 0;
   int jam_fall = 0;
   logic jam_prev = 1'b0;

   coin_acceptor #(
      .DEB_CYCLES(4),
      .MAX_PULSE (16),
      .CNT_W     (7)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .sense_a(sense_a),
      .sense_b(sense_b),
      .busy   (busy),
      .i      (i),
      .j      (j),
      .reject (reject),
      .jam    (jam)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor, sampled 2 time units after each rising edge.
   always begin
      @(posedge clk);
      #2;
      if (i) begin
         n_i++;
         last_j = int'(j);
         i_cyc = cyc;
      end
      if (reject) n_rej++;
      if (jam) n_jam++;
      if (jam && !jam_prev) begin
         n_jam_rise++;
         jam_rise = cyc;
      end
      if (!jam && jam_prev) jam_fall = cyc;
      jam_prev = jam;
      if ((int'(i) + int'(reject) + int'(jam)) > 1 || (!i && j)) n_bad++;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic hold(input logic a, input logic b, input int n);
      sense_a = a;
      sense_b = b;
      repeat (n) @(negedge clk);
   endtask

   int b_i, b_rej, b_jam, b_rise, t0;

   task automatic snap();
      b_i    = n_i;
      b_rej  = n_rej;
      b_jam  = n_jam;
      b_rise = n_jam_rise;
   endtask

   initial begin
      rst = 1'b1;
      sense_a = 1'b0;
      sense_b = 1'b0;
      busy = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_i", int'(i), 0);
      check("rst_j", int'(j), 0);
      check("rst_reject", int'(reject), 0);
      check("rst_jam", int'(jam), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // 1: small coin, exact latency from raw fall
      snap();
      hold(1'b1, 1'b0, 8);
      t0 = cyc;
      hold(1'b0, 1'b0, 10);
      check("small_i_count", n_i - b_i, 1);
      check("small_j", last_j, 0);
      check("small_latency", i_cyc - t0, 3);
      check("small_reject", n_rej - b_rej, 0);
      check("small_jam", n_jam - b_jam, 0);

      // 2: large coin, then invalid pattern
      snap();
      hold(1'b1, 1'b1, 8);
      hold(1'b0, 1'b0, 10);
      check("large_i_count", n_i - b_i, 1);
      check("large_j", last_j, 1);
      check("large_reject", n_rej - b_rej, 0);
      snap();
      hold(1'b0, 1'b1, 8);
      hold(1'b0, 1'b0, 10);
      check("invalid_reject", n_rej - b_rej, 1);
      check("invalid_i", n_i - b_i, 0);

      // 3: glitches never accepted
      snap();
      hold(1'b1, 1'b0, 2);
      for (int k = 0; k < 5; k++) begin
         hold(1'b0, 1'b0, 3);
         hold(1'b1, 1'b0, 1);
      end
      hold(1'b0, 1'b0, 10);
      check("glitch_i", n_i - b_i, 0);
      check("glitch_reject", n_rej - b_rej, 0);
      check("glitch_jam", n_jam - b_jam, 0);

      // 4: busy at acceptance drops the coin even if busy clears later
      snap();
      busy = 1'b1;
      hold(1'b1, 1'b0, 6);
      busy = 1'b0;
      hold(1'b1, 1'b0, 2);
      hold(1'b0, 1'b0, 10);
      check("busy_reject", n_rej - b_rej, 1);
      check("busy_i", n_i - b_i, 0);
      snap();
      hold(1'b1, 1'b0, 8);
      hold(1'b0, 1'b0, 10);
      check("nobusy_i", n_i - b_i, 1);
      check("nobusy_j", last_j, 0);
      check("nobusy_reject", n_rej - b_rej, 0);

      // 5: jam entry timing, interrupted release, clearing timing
      snap();
      t0 = cyc;
      hold(1'b1, 1'b0, 30);
      check("jam_rise_cycle", jam_rise - t0, 22);
      check("jam_rise_count", n_jam_rise - b_rise, 1);
      check("jam_held", int'(jam), 1);
      hold(1'b0, 1'b0, 3);
      hold(1'b1, 1'b0, 1);
      t0 = cyc;
      hold(1'b0, 1'b0, 4);
      check("jam_still_held", int'(jam), 1);
      hold(1'b0, 1'b0, 6);
      check("jam_cleared", int'(jam), 0);
      check("jam_fall_cycle", jam_fall - t0, 6);
      check("jam_i", n_i - b_i, 0);
      check("jam_reject", n_rej - b_rej, 0);

      // 6: reset in WAIT_RELEASE discards the coin
      snap();
      hold(1'b1, 1'b1, 8);
      rst = 1'b1;
      #1;
      check("midrst_i", int'(i), 0);
      check("midrst_reject", int'(reject), 0);
      check("midrst_jam", int'(jam), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      hold(1'b0, 1'b0, 10);
      check("postrst_i", n_i - b_i, 0);
      check("postrst_reject", n_rej - b_rej, 0);
      snap();
      hold(1'b1, 1'b0, 8);
      hold(1'b0, 1'b0, 10);
      check("postrst_coin_i", n_i - b_i, 1);
      check("postrst_coin_j", last_j, 0);

      check("exclusive_outputs", n_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
